// File: rtl/ssd1306_pkg.sv
// Shared opcodes, encodings and reset defaults for the SSD1306 serial-interface model.
package ssd1306_pkg;

  localparam logic [7:0] CMD_SET_MODE    = 8'h20;
  localparam logic [7:0] CMD_SET_COL     = 8'h21;
  localparam logic [7:0] CMD_SET_PAGE    = 8'h22;
  localparam logic [7:0] CMD_CONTRAST    = 8'h81;
  localparam logic [7:0] CMD_CHARGE_PUMP = 8'h8D;
  localparam logic [7:0] CMD_MUX_RATIO   = 8'hA8;
  localparam logic [7:0] CMD_DISP_OFF    = 8'hAE;
  localparam logic [7:0] CMD_DISP_ON     = 8'hAF;
  localparam logic [7:0] CMD_DISP_OFFSET = 8'hD3;
  localparam logic [7:0] CMD_CLK_DIV     = 8'hD5;
  localparam logic [7:0] CMD_PRECHARGE   = 8'hD9;
  localparam logic [7:0] CMD_COM_PINS    = 8'hDA;
  localparam logic [7:0] CMD_VCOMH       = 8'hDB;

  localparam logic [6:0] COL_END_RST  = 7'd127;
  localparam logic [2:0] PAGE_END_RST = 3'd7;
  localparam logic [7:0] CONTRAST_RST = 8'h7F;

  typedef enum logic [1:0] {
    MODE_HORZ = 2'd0,
    MODE_VERT = 2'd1,
    MODE_PAGE = 2'd2
  } addr_mode_e;

  typedef enum logic [1:0] {
    PS_IDLE = 2'd0,
    PS_ARG1 = 2'd1,
    PS_ARG2 = 2'd2
  } parser_state_e;

  function automatic logic is_two_arg_cmd(input logic [7:0] b);
    return (b == CMD_SET_COL) || (b == CMD_SET_PAGE);
  endfunction

  function automatic logic is_one_arg_cmd(input logic [7:0] b);
    case (b)
      CMD_SET_MODE, CMD_CONTRAST, CMD_CHARGE_PUMP, CMD_MUX_RATIO,
      CMD_DISP_OFFSET, CMD_CLK_DIV, CMD_PRECHARGE, CMD_COM_PINS,
      CMD_VCOMH: return 1'b1;
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ssd1306_spi_sink_rx.sv
// SPI mode-0 byte receiver: synchronises SCK/MOSI/CS_L/DC into i_Clk, detects
// SCK rising edges and presents each completed byte with a one-cycle valid.
module spi_slave_rx
  #(parameter int SYNC_STAGES = 2)
  (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_SPI_Clk,
    input  logic       i_SPI_MOSI,
    input  logic       i_CS_L,
    input  logic       i_DC,
    output logic       o_Valid,
    output logic [7:0] o_Byte,
    output logic       o_DC
  );

  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] dc_sync;
  logic                   sck_prev;
  logic [6:0]             shift_q;
  logic [2:0]             count_q;

  logic sck_s;
  logic mosi_s;
  logic cs_s;
  logic dc_s;
  logic sck_rise;

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign dc_s     = dc_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev;

  // NOTE: non-blocking assignments make each sync stage take the previous stage's old value.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sck_sync  <= '0;
      mosi_sync <= '0;
      cs_sync   <= '1;
      dc_sync   <= '0;
      sck_prev  <= 1'b0;
      shift_q   <= '0;
      count_q   <= '0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0],  i_SPI_Clk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], i_SPI_MOSI};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0],   i_CS_L};
      dc_sync   <= {dc_sync[SYNC_STAGES-2:0],   i_DC};
      sck_prev  <= sck_s;
      // A deselected link drops any partial byte; the stale shift bits are overwritten later.
      if (cs_s) begin
        count_q <= '0;
      end else if (sck_rise) begin
        shift_q <= {shift_q[5:0], mosi_s};
        count_q <= count_q + 3'd1;
      end
    end
  end

  // Valid is combinational in the 8th-edge cycle so the consumer's registers add the single cycle of latency.
  assign o_Valid = sck_rise & ~cs_s & (count_q == 3'd7);
  assign o_Byte  = {shift_q, mosi_s};
  assign o_DC    = dc_s;

endmodule

// File: rtl/ssd1306_spi_sink.sv
// SSD1306 4-wire serial interface model: decodes command bytes into display and
// addressing state and turns data bytes into auto-incrementing framebuffer writes.
module ssd1306_spi_sink
  import ssd1306_pkg::*;
  #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [1:0] RESET_MODE  = 2'd2
  )
  (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_SPI_Clk,
    input  logic       i_SPI_MOSI,
    input  logic       i_CS_L,
    input  logic       i_DC,
    output logic       o_Wr_Enable,
    output logic [9:0] o_Wr_Address,
    output logic [7:0] o_Wr_Data,
    output logic       o_Byte_DV,
    output logic [7:0] o_Byte,
    output logic       o_Display_On,
    output logic [7:0] o_Contrast,
    output logic       o_Frame_Done
  );

  logic       rx_valid;
  logic [7:0] rx_byte;
  logic       rx_dc;

  spi_slave_rx #(.SYNC_STAGES(SYNC_STAGES)) u_rx (
    .i_Clk      (i_Clk),
    .i_Rst_L    (i_Rst_L),
    .i_SPI_Clk  (i_SPI_Clk),
    .i_SPI_MOSI (i_SPI_MOSI),
    .i_CS_L     (i_CS_L),
    .i_DC       (i_DC),
    .o_Valid    (rx_valid),
    .o_Byte     (rx_byte),
    .o_DC       (rx_dc)
  );

  parser_state_e state_q, state_d;
  logic [7:0]    cmd_q, cmd_d;
  logic [6:0]    arg1_q, arg1_d;
  addr_mode_e    mode_q, mode_d;
  logic [6:0]    col_start_q, col_start_d, col_end_q, col_end_d, col_q, col_d;
  logic [2:0]    page_start_q, page_start_d, page_end_q, page_end_d, page_q, page_d;

  logic       wr_en_d, byte_dv_d, disp_on_d, frame_done_d;
  logic [9:0] wr_addr_d;
  logic [7:0] wr_data_d, byte_d, contrast_d;

  // Wrap at the window end, or at the field maximum when the window is inverted.
  logic       col_wrap, page_wrap;
  logic [6:0] col_inc;
  logic [2:0] page_inc;

  assign col_wrap  = (col_q == col_end_q) || (col_q == 7'h7F);
  assign page_wrap = (page_q == page_end_q) || (page_q == 3'h7);
  assign col_inc   = col_wrap  ? col_start_q  : col_q + 7'd1;
  assign page_inc  = page_wrap ? page_start_q : page_q + 3'd1;

  // NOTE: every target is defaulted at the top of the block so no latch is inferred.
  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    arg1_d       = arg1_q;
    mode_d       = mode_q;
    col_start_d  = col_start_q;
    col_end_d    = col_end_q;
    col_d        = col_q;
    page_start_d = page_start_q;
    page_end_d   = page_end_q;
    page_d       = page_q;
    disp_on_d    = o_Display_On;
    contrast_d   = o_Contrast;
    byte_dv_d    = 1'b0;
    byte_d       = o_Byte;
    wr_en_d      = 1'b0;
    wr_addr_d    = o_Wr_Address;
    wr_data_d    = o_Wr_Data;
    frame_done_d = 1'b0;

    if (rx_valid) begin
      byte_dv_d = 1'b1;
      byte_d    = rx_byte;
      if (rx_dc) begin
        // Data aborts any half-received command sequence.
        state_d   = PS_IDLE;
        wr_en_d   = 1'b1;
        wr_addr_d = {page_q, col_q};
        wr_data_d = rx_byte;
        unique case (mode_q)
          MODE_HORZ: begin
            col_d        = col_inc;
            if (col_wrap) page_d = page_inc;
            frame_done_d = col_wrap & page_wrap;
          end
          MODE_VERT: begin
            page_d       = page_inc;
            if (page_wrap) col_d = col_inc;
            frame_done_d = col_wrap & page_wrap;
          end
          default: col_d = col_inc;
        endcase
      end else begin
        unique case (state_q)
          PS_IDLE: begin
            cmd_d = rx_byte;
            if (is_two_arg_cmd(rx_byte) || is_one_arg_cmd(rx_byte)) begin
              state_d = PS_ARG1;
            end else if (rx_byte == CMD_DISP_OFF) begin
              disp_on_d = 1'b0;
            end else if (rx_byte == CMD_DISP_ON) begin
              disp_on_d = 1'b1;
            end else if (rx_byte[7:3] == 5'b10110) begin
              page_d = rx_byte[2:0];
            end else if (rx_byte[7:4] == 4'h0) begin
              col_d[3:0] = rx_byte[3:0];
            end else if (rx_byte[7:3] == 5'b00010) begin
              col_d[6:4] = rx_byte[2:0];
            end
          end
          PS_ARG1: begin
            if (is_two_arg_cmd(cmd_q)) begin
              arg1_d  = rx_byte[6:0];
              state_d = PS_ARG2;
            end else begin
              state_d = PS_IDLE;
              if (cmd_q == CMD_SET_MODE && rx_byte[1:0] != 2'd3) begin
                mode_d = addr_mode_e'(rx_byte[1:0]);
              end else if (cmd_q == CMD_CONTRAST) begin
                contrast_d = rx_byte;
              end
            end
          end
          PS_ARG2: begin
            state_d = PS_IDLE;
            if (cmd_q == CMD_SET_COL) begin
              col_start_d = arg1_q;
              col_end_d   = rx_byte[6:0];
              col_d       = arg1_q;
            end else begin
              page_start_d = arg1_q[2:0];
              page_end_d   = rx_byte[2:0];
              page_d       = arg1_q[2:0];
            end
          end
          default: state_d = PS_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q      <= PS_IDLE;
      cmd_q        <= '0;
      arg1_q       <= '0;
      mode_q       <= addr_mode_e'(RESET_MODE);
      col_start_q  <= '0;
      col_end_q    <= COL_END_RST;
      col_q        <= '0;
      page_start_q <= '0;
      page_end_q   <= PAGE_END_RST;
      page_q       <= '0;
      o_Display_On <= 1'b0;
      o_Contrast   <= CONTRAST_RST;
      o_Byte_DV    <= 1'b0;
      o_Byte       <= '0;
      o_Wr_Enable  <= 1'b0;
      o_Wr_Address <= '0;
      o_Wr_Data    <= '0;
      o_Frame_Done <= 1'b0;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      arg1_q       <= arg1_d;
      mode_q       <= mode_d;
      col_start_q  <= col_start_d;
      col_end_q    <= col_end_d;
      col_q        <= col_d;
      page_start_q <= page_start_d;
      page_end_q   <= page_end_d;
      page_q       <= page_d;
      o_Display_On <= disp_on_d;
      o_Contrast   <= contrast_d;
      o_Byte_DV    <= byte_dv_d;
      o_Byte       <= byte_d;
      o_Wr_Enable  <= wr_en_d;
      o_Wr_Address <= wr_addr_d;
      o_Wr_Data    <= wr_data_d;
      o_Frame_Done <= frame_done_d;
    end
  end

endmodule
